// File: rtl/ftdi_cmd_pkg.sv
// Purpose: shared state encoding and protocol byte values for the FTDI register-access parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ftdi_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_SEND_ACK,
        ST_SEND_DATA,
        ST_SEND_CHK,
        ST_SEND_NAK
    } state_t;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

endpackage

// File: rtl/rx_byte_fetch.sv
// Purpose: pops bytes from the FTDI RX FIFO and hands them to the parser as a byte/valid pair.
// Latency: byte valid the cycle after the pop strobe; at most one pop every two cycles.
// Backpressure: pops only while fetch_en is high and the FIFO is not empty.
//
// Ports: clk/rst_n; fetch_en (parser wants a byte), timer_en (parser is mid-frame);
//        rx_empty/rx_data/rx_en to the FIFO; byte_vld/byte_dat/timeout to the parser.
// Optional inter-byte timeout is built only with CMD_PARSER_TIMEOUT_EN defined.
module rx_byte_fetch
    import ftdi_cmd_pkg::*;
#(
    parameter int pTimeoutCycles = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_en,
    input  logic       timer_en,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       timeout
);

    logic armed_q;  // keeps the pop strobe low while reset is asserted
    logic pop_q;    // a pop was issued last cycle; its byte is on rx_data now

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            pop_q   <= rx_en;
        end
    end

    // Blocking on pop_q both spaces pops and prevents a pop in the capture
    // cycle, so the parser never has a stray byte in flight when it leaves
    // the fetch states.
    assign rx_en    = armed_q & fetch_en & ~rx_empty & ~pop_q;
    assign byte_vld = pop_q;
    assign byte_dat = rx_data;

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int CW = $clog2(pTimeoutCycles + 1);
    logic [CW-1:0] gap_cnt;

    // Fires on the pTimeoutCycles-th consecutive mid-frame cycle without a byte.
    assign timeout = timer_en & ~pop_q & (gap_cnt == CW'(pTimeoutCycles - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (!timer_en || pop_q || timeout) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (pTimeoutCycles != 0) | timer_en;
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/ftdi_cmd_parser.sv
// Purpose: parses A5/CMD/ADDR/[DATA]/CHK frames from the FTDI RX FIFO into single-byte register accesses.
// Latency: oRegWr/oRegRd one cycle after CHK capture; ACK one cycle after a write, two after a read.
// Backpressure: TX pushes stall (state and oTxData held) while iTxFull is high; RX pops pace the parser.
//
// Ports: iClk/iRst_n; oRxEn/iRxEmpty/iRxData (RX FIFO pop side); oTxEn/iTxFull/oTxData (TX FIFO push side);
//        oRegAddr/oRegWrData/oRegWr/oRegRd/iRegRdData (register bank); oFrameErr, oBusy (status).
// Build option: CMD_PARSER_TIMEOUT_EN enables the mid-frame inter-byte timeout (pTimeoutCycles).
module ftdi_cmd_parser
    import ftdi_cmd_pkg::*;
#(
    parameter int pAddrWidth     = 8,
    parameter int pTimeoutCycles = 1000000
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    output logic                  oRxEn,
    input  logic                  iRxEmpty,
    input  logic [7:0]            iRxData,
    output logic                  oTxEn,
    input  logic                  iTxFull,
    output logic [7:0]            oTxData,
    output logic [pAddrWidth-1:0] oRegAddr,
    output logic [7:0]            oRegWrData,
    output logic                  oRegWr,
    output logic                  oRegRd,
    input  logic [7:0]            iRegRdData,
    output logic                  oFrameErr,
    output logic                  oBusy
);

    state_t                state_q;
    logic [7:0]            cmd_q;
    logic [pAddrWidth-1:0] addr_q;
    logic [7:0]            data_q;
    logic [7:0]            chk_q;
    logic [7:0]            rd_data_q;

    logic       byte_vld;
    logic [7:0] byte_dat;
    logic       timeout;
    logic       fetch_en;
    logic       timer_en;
    logic       in_send;
    logic       is_wr;

    assign fetch_en = (state_q == ST_IDLE)     || (state_q == ST_GET_CMD) ||
                      (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) ||
                      (state_q == ST_GET_CHK);
    assign timer_en = fetch_en && (state_q != ST_IDLE);
    assign in_send  = (state_q == ST_SEND_ACK) || (state_q == ST_SEND_DATA) ||
                      (state_q == ST_SEND_CHK) || (state_q == ST_SEND_NAK);
    assign is_wr    = (cmd_q == CMD_WR);

    assign oTxEn = in_send & ~iTxFull;
    assign oBusy = (state_q != ST_IDLE);

    rx_byte_fetch #(
        .pTimeoutCycles(pTimeoutCycles)
    ) u_fetch (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .fetch_en (fetch_en),
        .timer_en (timer_en),
        .rx_empty (iRxEmpty),
        .rx_data  (iRxData),
        .rx_en    (oRxEn),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .timeout  (timeout)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            rd_data_q  <= '0;
            oTxData    <= '0;
            oRegAddr   <= '0;
            oRegWrData <= '0;
            oRegWr     <= 1'b0;
            oRegRd     <= 1'b0;
            oFrameErr  <= 1'b0;
        end else begin
            oRegWr    <= 1'b0;
            oRegRd    <= 1'b0;
            oFrameErr <= 1'b0;

            if (timeout) begin
                // Stalled mid-frame: drop the frame silently and hunt for SYNC.
                state_q   <= ST_IDLE;
                oFrameErr <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (byte_vld && byte_dat == SYNC) state_q <= ST_GET_CMD;
                    end
                    ST_GET_CMD: begin
                        if (byte_vld) begin
                            cmd_q <= byte_dat;
                            chk_q <= byte_dat;
                            if (byte_dat == CMD_WR || byte_dat == CMD_RD) begin
                                state_q <= ST_GET_ADDR;
                            end else begin
                                oTxData   <= NAK;
                                oFrameErr <= 1'b1;
                                state_q   <= ST_SEND_NAK;
                            end
                        end
                    end
                    ST_GET_ADDR: begin
                        if (byte_vld) begin
                            addr_q  <= byte_dat[pAddrWidth-1:0];
                            chk_q   <= chk_q ^ byte_dat;
                            state_q <= is_wr ? ST_GET_DATA : ST_GET_CHK;
                        end
                    end
                    ST_GET_DATA: begin
                        if (byte_vld) begin
                            data_q  <= byte_dat;
                            chk_q   <= chk_q ^ byte_dat;
                            state_q <= ST_GET_CHK;
                        end
                    end
                    ST_GET_CHK: begin
                        if (byte_vld) begin
                            if (byte_dat == chk_q) begin
                                // Strobes and bus values are registered here so
                                // they appear together in the EXEC cycle.
                                oRegAddr <= addr_q;
                                if (is_wr) oRegWrData <= data_q;
                                oRegWr   <= is_wr;
                                oRegRd   <= ~is_wr;
                                oTxData  <= ACK;
                                state_q  <= ST_EXEC;
                            end else begin
                                oTxData   <= NAK;
                                oFrameErr <= 1'b1;
                                state_q   <= ST_SEND_NAK;
                            end
                        end
                    end
                    ST_EXEC: begin
                        state_q <= is_wr ? ST_SEND_ACK : ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        rd_data_q <= iRegRdData;
                        state_q   <= ST_SEND_ACK;
                    end
                    ST_SEND_ACK: begin
                        if (!iTxFull) begin
                            if (is_wr) begin
                                state_q <= ST_IDLE;
                            end else begin
                                oTxData <= rd_data_q;
                                state_q <= ST_SEND_DATA;
                            end
                        end
                    end
                    ST_SEND_DATA: begin
                        if (!iTxFull) begin
                            oTxData <= ACK ^ rd_data_q;
                            state_q <= ST_SEND_CHK;
                        end
                    end
                    ST_SEND_CHK, ST_SEND_NAK: begin
                        if (!iTxFull) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ftdi_cmd_parser.sv
// Purpose: self-checking bench for ftdi_cmd_parser: directed frames plus random streams against a frame-level model.
// Latency: n/a.
// Backpressure: bench drives iTxFull and RX FIFO stalls; FIFO/register-bank models update just after the clock edge.
module tb_ftdi_cmd_parser;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       oRxEn;
    logic       iRxEmpty;
    logic [7:0] iRxData;
    logic       oTxEn;
    logic       iTxFull;
    logic [7:0] oTxData;
    logic [7:0] oRegAddr;
    logic [7:0] oRegWrData;
    logic       oRegWr;
    logic       oRegRd;
    logic [7:0] iRegRdData;
    logic       oFrameErr;
    logic       oBusy;

    always #5 iClk = ~iClk;

    ftdi_cmd_parser #(
        .pAddrWidth    (8),
        .pTimeoutCycles(16)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .oRxEn     (oRxEn),
        .iRxEmpty  (iRxEmpty),
        .iRxData   (iRxData),
        .oTxEn     (oTxEn),
        .iTxFull   (iTxFull),
        .oTxData   (oTxData),
        .oRegAddr  (oRegAddr),
        .oRegWrData(oRegWrData),
        .oRegWr    (oRegWr),
        .oRegRd    (oRegRd),
        .iRegRdData(iRegRdData),
        .oFrameErr (oFrameErr),
        .oBusy     (oBusy)
    );

    // Environment: RX FIFO contents, register bank, observed traffic.
    logic [7:0]  rx_q[$];
    logic [7:0]  regs[256];
    logic [7:0]  tx_got[$];
    int          tx_cyc[$];
    logic [15:0] wr_got[$];
    logic [7:0]  rd_got[$];
    int          err_got, err_cyc, wr_cyc, wr_pop, rd_cyc, rd_pop, last_pop_cyc, cyc;
    bit          pend_pop, pend_rd, prev_pop, prev_full;
    logic [7:0]  pend_rd_addr, prev_tx;
    bit          full_req, rand_full, rand_stall, chk_stable;
    int          bp_viol, stable_viol, b2b_viol;

    // Reference expectations.
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          exp_err;
    logic [7:0]  mregs[256];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < tx_got.size()) ? {24'h0, tx_got[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int txc_at(input int i);
        return (i < tx_cyc.size()) ? tx_cyc[i] : -1000;
    endfunction

    // One clock: apply FIFO/bank effects and input changes just after the
    // edge, then sample DUT outputs on the falling edge.
    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
        if (pend_pop) begin
            if (rx_q.size() > 0) iRxData = rx_q.pop_front();
            pend_pop = 1'b0;
        end
        if (pend_rd) begin
            iRegRdData = regs[pend_rd_addr];
            pend_rd    = 1'b0;
        end
        iTxFull  = full_req || (rand_full && ($urandom_range(0, 3) == 0));
        iRxEmpty = (rx_q.size() == 0) || (rand_stall && ($urandom_range(0, 4) == 0));
        @(negedge iClk);
        if (oRxEn) begin
            pend_pop = 1'b1;
            if (prev_pop) b2b_viol++;
            last_pop_cyc = cyc;
        end
        prev_pop = oRxEn;
        if (oTxEn) begin
            tx_got.push_back(oTxData);
            tx_cyc.push_back(cyc);
            if (iTxFull) bp_viol++;
        end
        if (oRegWr) begin
            wr_got.push_back({oRegAddr, oRegWrData});
            regs[oRegAddr] = oRegWrData;
            wr_cyc = cyc;
            wr_pop = last_pop_cyc;
        end
        if (oRegRd) begin
            rd_got.push_back(oRegAddr);
            pend_rd      = 1'b1;
            pend_rd_addr = oRegAddr;
            rd_cyc       = cyc;
            rd_pop       = last_pop_cyc;
        end
        if (oFrameErr) begin
            err_got++;
            err_cyc = cyc;
        end
        if (chk_stable && iTxFull && prev_full && (oTxData !== prev_tx)) stable_viol++;
        prev_full = iTxFull;
        prev_tx   = oTxData;
    endtask

    task automatic clear_obs();
        tx_got.delete(); tx_cyc.delete(); wr_got.delete(); rd_got.delete();
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        err_got = 0;
        exp_err = 0;
    endtask

    // Frame-level reference: walks the byte list, hunting SYNC, and emits
    // the register accesses and TX bytes each complete frame should cause.
    task automatic model_run(input logic [7:0] s[$]);
        int i = 0;
        int n = s.size();
        int len;
        logic [7:0] cmd, a, d, x;
        for (int k = 0; k < 256; k++) mregs[k] = regs[k];
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            cmd = s[i+1];
            if (cmd != 8'h01 && cmd != 8'h02) begin
                exp_tx.push_back(8'h15);
                exp_err++;
                i += 2;
                continue;
            end
            len = (cmd == 8'h01) ? 5 : 4;
            if (i + len > n) break;
            a = s[i+2];
            d = (cmd == 8'h01) ? s[i+3] : 8'h00;
            x = cmd ^ a ^ d;
            if (x != s[i+len-1]) begin
                exp_tx.push_back(8'h15);
                exp_err++;
            end else if (cmd == 8'h01) begin
                exp_wr.push_back({a, d});
                mregs[a] = d;
                exp_tx.push_back(8'h06);
            end else begin
                exp_rd.push_back(a);
                exp_tx.push_back(8'h06);
                exp_tx.push_back(mregs[a]);
                exp_tx.push_back(8'h06 ^ mregs[a]);
            end
            i += len;
        end
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int k = 0; k < 20000 && quiet < 4; k++) begin
            tick();
            if (rx_q.size() == 0 && !oBusy && !pend_pop) quiet++;
            else quiet = 0;
        end
        check($sformatf("%s_drain", tag), (quiet >= 4), 1);
    endtask

    task automatic start_stream(input logic [7:0] s[$]);
        clear_obs();
        model_run(s);
        foreach (s[k]) rx_q.push_back(s[k]);
    endtask

    task automatic end_stream(input string tag);
        wait_idle(tag);
        check($sformatf("%s_ntx", tag), tx_got.size(), exp_tx.size());
        for (int k = 0; k < exp_tx.size(); k++)
            check($sformatf("%s_tx%0d", tag, k), tx_at(k), {24'h0, exp_tx[k]});
        check($sformatf("%s_nwr", tag), wr_got.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < wr_got.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), {16'h0, wr_got[k]}, {16'h0, exp_wr[k]});
        check($sformatf("%s_nrd", tag), rd_got.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size() && k < rd_got.size(); k++)
            check($sformatf("%s_rd%0d", tag, k), {24'h0, rd_got[k]}, {24'h0, exp_rd[k]});
        check($sformatf("%s_err", tag), err_got, exp_err);
    endtask

    task automatic run_stream(input logic [7:0] s[$], input string tag);
        start_stream(s);
        end_stream(tag);
    endtask

    task automatic gen_random(output logic [7:0] s[$], input int nframes);
        logic [7:0] a, d, c, k;
        s.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                k = 8'($urandom_range(0, 255));
                s.push_back((k == 8'hA5) ? 8'h00 : k);
            end
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0, 1: s = {s, 8'hA5, 8'h01, a, d, 8'h01 ^ a ^ d};
                2, 3: s = {s, 8'hA5, 8'h02, a, 8'h02 ^ a};
                4: begin
                    k = 8'h01 << $urandom_range(0, 7);
                    if ($urandom_range(0, 1) == 0) s = {s, 8'hA5, 8'h01, a, d, 8'h01 ^ a ^ d ^ k};
                    else                           s = {s, 8'hA5, 8'h02, a, 8'h02 ^ a ^ k};
                end
                default: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h01 || c == 8'h02) c = 8'h33;
                    s = {s, 8'hA5, c};
                end
            endcase
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        iRst_n     = 1'b0;
        iRxEmpty   = 1'b1;
        iRxData    = 8'h00;
        iTxFull    = 1'b0;
        iRegRdData = 8'h00;
        {pend_pop, pend_rd, prev_pop, prev_full} = '0;
        {full_req, rand_full, rand_stall, chk_stable} = '0;
        {bp_viol, stable_viol, b2b_viol, cyc, last_pop_cyc} = '0;
        {err_cyc, wr_cyc, wr_pop, rd_cyc, rd_pop} = '0;
        pend_rd_addr = 8'h00;
        prev_tx = 8'h00;
        for (int k = 0; k < 256; k++) regs[k] = 8'($urandom_range(0, 255));
        clear_obs();

        // Reset state, with a byte already waiting in the RX FIFO.
        rx_q.push_back(8'h00);
        tick();
        tick();
        check("rst_rxen",  oRxEn, 0);
        check("rst_txen",  oTxEn, 0);
        check("rst_regwr", oRegWr, 0);
        check("rst_regrd", oRegRd, 0);
        check("rst_ferr",  oFrameErr, 0);
        check("rst_busy",  oBusy, 0);
        check("rst_txdat", oTxData, 0);
        check("rst_addr",  oRegAddr, 0);
        check("rst_wdat",  oRegWrData, 0);
        check("rst_nopop", pend_pop, 0);
        iRst_n = 1'b1;

        // Stray non-SYNC byte is swallowed without any response.
        clear_obs();
        wait_idle("garbage0");
        check("garbage0_ntx", tx_got.size(), 0);

        // Plain write.
        s = {8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
        run_stream(s, "wr");
        check("wr_ack",      tx_at(0), 32'h06);
        check("wr_val",      (wr_got.size() > 0) ? {16'h0, wr_got[0]} : 32'hFFFF_FFFF, 32'h103C);
        check("wr_lat",      wr_cyc - wr_pop, 2);
        check("wr_ack_lat",  txc_at(0) - wr_cyc, 1);
        check("wr_addr_hold", oRegAddr, 8'h10);
        check("wr_data_hold", oRegWrData, 8'h3C);

        // Plain read.
        regs[8'h20] = 8'h5A;
        s = {8'hA5, 8'h02, 8'h20, 8'h22};
        run_stream(s, "rd");
        check("rd_b0",      tx_at(0), 32'h06);
        check("rd_b1",      tx_at(1), 32'h5A);
        check("rd_b2",      tx_at(2), 32'h5C);
        check("rd_lat",     rd_cyc - rd_pop, 2);
        check("rd_ack_lat", txc_at(0) - rd_cyc, 2);
        check("rd_b2b_tx",  txc_at(2) - txc_at(0), 2);

        // Bad checksum, then a good write.
        s = {8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00, 8'hA5, 8'h01, 8'h11, 8'h44, 8'h54};
        run_stream(s, "badchk");
        check("badchk_nak", tx_at(0), 32'h15);
        check("badchk_ack", tx_at(1), 32'h06);
        check("badchk_err", err_got, 1);

        // Leading garbage, good write, unknown command.
        s = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D, 8'hA5, 8'h07};
        run_stream(s, "garbage");
        check("garbage_ack", tx_at(0), 32'h06);
        check("garbage_nak", tx_at(1), 32'h15);

        // TX back-pressure for 10 cycles from SEND_ACK of a read.
        regs[8'h20] = 8'h5A;
        s = {8'hA5, 8'h02, 8'h20, 8'h22};
        start_stream(s);
        for (int k = 0; k < 200 && rd_got.size() == 0; k++) tick();
        tick();
        full_req   = 1'b1;
        chk_stable = 1'b1;
        repeat (10) tick();
        full_req = 1'b0;
        check("bp_held_dat", oTxData, 8'h06);
        check("bp_none_yet", tx_got.size(), 0);
        end_stream("bp");
        chk_stable = 1'b0;
        check("bp_b0", tx_at(0), 32'h06);
        check("bp_b1", tx_at(1), 32'h5A);
        check("bp_b2", tx_at(2), 32'h5C);
        check("bp_txen_while_full", bp_viol, 0);
        check("bp_txdat_stable", stable_viol, 0);

        // Stalled frame.
        clear_obs();
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h01);
        repeat (40) tick();
`ifdef CMD_PARSER_TIMEOUT_EN
        check("to_err",  err_got, 1);
        check("to_gap",  err_cyc - last_pop_cyc, 18);
        check("to_idle", oBusy, 0);
        check("to_ntx",  tx_got.size(), 0);
        s = {8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
        run_stream(s, "to_after");
`else
        check("to_noerr", err_got, 0);
        check("to_busy",  oBusy, 1);
        check("to_ntx",   tx_got.size(), 0);
        // Reset mid-frame drops the partial frame.
        iRst_n = 1'b0;
        rx_q.delete();
        pend_pop = 1'b0;
        pend_rd  = 1'b0;
        tick();
        check("midrst_busy", oBusy, 0);
        iRst_n = 1'b1;
        s = {8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
        run_stream(s, "midrst_after");
`endif

        // Random streams with TX back-pressure and RX stalls.
        rand_full  = 1'b1;
        rand_stall = 1'b1;
        for (int r = 0; r < 4; r++) begin
            gen_random(s, 30);
            run_stream(s, $sformatf("rand%0d", r));
        end
        rand_full  = 1'b0;
        rand_stall = 1'b0;
        check("txen_while_full", bp_viol, 0);
        check("rx_pop_b2b", b2b_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
